jk_key_conditioner: RTL and testbench

Front-end conditioner that turns two noisy, active-low push-buttons into the clean `j`/`k` controls consumed by the two-state Moore toggle FSM. Each channel does three things:
- synchronises the raw key,
- debounces it with a per-channel counter and state machine,
- emits exactly one single-cycle pulse per confirmed press, plus a debounced held level.

It sits directly upstream of that FSM, in the same clock domain.

---
 rtl/jk_key_conditioner.sv | 129 ++++++++++++
 tb/tb_jk_key_conditioner.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/jk_key_conditioner.sv
// Two-channel push-button conditioner: synchronise, debounce and pulse-on-press
// for the active-low J and K keys feeding the toggle FSM.

module jk_key_channel #(
    parameter int DEB_CYCLES = 50000,
    parameter int CNT_W      = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic pulse,
    output logic held
);
    // state     | meaning
    // IDLE      | key released and stable
    // PRESS_CHK | key seen down, counting stable pressed samples
    // HELD      | press confirmed, waiting for release
    // REL_CHK   | key seen up, counting stable released samples
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             pressed;
    state_t           state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key_n};
        end
    end

    assign pressed = ~sync_q[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (pressed) begin
                        state <= PRESS_CHK;
                        cnt   <= '0;
                    end
                end
                PRESS_CHK: begin
                    if (!pressed) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= HELD;
                        pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!pressed) begin
                        state <= REL_CHK;
                        cnt   <= '0;
                    end
                end
                REL_CHK: begin
                    // a press during release checking is bounce, not a new press
                    if (pressed) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign held = (state == HELD) || (state == REL_CHK);

endmodule

module jk_key_conditioner #(
    parameter int DEB_CYCLES = 50000,
    parameter int CNT_W      = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic key_j_n,
    input  logic key_k_n,
    output logic j,
    output logic k,
    output logic j_held,
    output logic k_held
);

    jk_key_channel #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) u_chan_j (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_j_n),
        .pulse (j),
        .held  (j_held)
    );

    jk_key_channel #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) u_chan_k (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_k_n),
        .pulse (k),
        .held  (k_held)
    );

endmodule

// File: tb/tb_jk_key_conditioner.sv
// Scoreboard bench for jk_key_conditioner: directed key waveforms push expected
// pulse/held events; a negedge monitor pops and compares them.

module tb_jk_key_conditioner;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic key_j_n = 1'b1;
    logic key_k_n = 1'b1;
    logic j, k, j_held, k_held;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int         cyc;
        logic [1:0] val;
    } ev_t;

    ev_t pulse_q[$];
    ev_t held_q[$];

    jk_key_conditioner #(
        .DEB_CYCLES (D),
        .CNT_W      (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .key_j_n (key_j_n),
        .key_k_n (key_k_n),
        .j       (j),
        .k       (k),
        .j_held  (j_held),
        .k_held  (k_held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void exp_pulse(input int c, input logic [1:0] v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        pulse_q.push_back(e);
    endfunction

    function automatic void exp_held(input int c, input logic [1:0] v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        held_q.push_back(e);
    endfunction

    function automatic void chk(input string name, input int got, input int req);
        n_vec++;
        if (got != req) begin
            n_err++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // monitor: every pulse and every held-level change must match the next expectation
    initial begin : monitor
        logic [1:0] prev_held;
        ev_t        e;
        prev_held = 2'b00;
        forever begin
            @(negedge clk);
            if ({j, k} != 2'b00) begin
                n_vec++;
                if (pulse_q.size() == 0) begin
                    n_err++;
                    $display("FAIL pulse_unexpected cyc=%0d jk=%b required none", cyc, {j, k});
                end else begin
                    e = pulse_q.pop_front();
                    if (e.cyc != cyc || e.val != {j, k}) begin
                        n_err++;
                        $display("FAIL pulse cyc=%0d jk=%b required cyc=%0d jk=%b",
                                 cyc, {j, k}, e.cyc, e.val);
                    end
                end
            end
            if ({j_held, k_held} != prev_held) begin
                n_vec++;
                if (held_q.size() == 0) begin
                    n_err++;
                    $display("FAIL held_unexpected cyc=%0d held=%b required %b",
                             cyc, {j_held, k_held}, prev_held);
                end else begin
                    e = held_q.pop_front();
                    if (e.cyc != cyc || e.val != {j_held, k_held}) begin
                        n_err++;
                        $display("FAIL held cyc=%0d held=%b required cyc=%0d held=%b",
                                 cyc, {j_held, k_held}, e.cyc, e.val);
                    end
                end
            end
            prev_held = {j_held, k_held};
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog time limit reached, %0d miscompares so far", n_err);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int c0;
        int c1;

        // reset state
        #3;
        chk("reset_outputs", int'({j, k, j_held, k_held}), 0);
        tick(2);
        rst = 1'b1;
        tick(3);

        // clean J press, 20 cycles, clean release
        c0 = cyc;
        key_j_n = 1'b0;
        exp_pulse(c0 + D + 3, 2'b10);
        exp_held(c0 + D + 3, 2'b10);
        tick(20);
        c1 = cyc;
        key_j_n = 1'b1;
        exp_held(c1 + D + 3, 2'b00);
        tick(D + 8);

        // J bounce 3 low / 2 high / 3 low: rejected
        key_j_n = 1'b0; tick(3);
        key_j_n = 1'b1; tick(2);
        key_j_n = 1'b0; tick(3);
        key_j_n = 1'b1; tick(8);
        // low for exactly D raw cycles: still rejected
        key_j_n = 1'b0; tick(D);
        key_j_n = 1'b1; tick(8);
        // low for D+1 raw cycles: shortest accepted press
        c0 = cyc;
        key_j_n = 1'b0;
        exp_pulse(c0 + D + 3, 2'b10);
        exp_held(c0 + D + 3, 2'b10);
        tick(D + 1);
        c1 = cyc;
        key_j_n = 1'b1;
        exp_held(c1 + D + 3, 2'b00);
        tick(D + 8);

        // K press with release bounces of 2 and D cycles
        c0 = cyc;
        key_k_n = 1'b0;
        exp_pulse(c0 + D + 3, 2'b01);
        exp_held(c0 + D + 3, 2'b01);
        tick(12);
        key_k_n = 1'b1; tick(2);
        key_k_n = 1'b0; tick(5);
        key_k_n = 1'b1; tick(D);
        key_k_n = 1'b0; tick(5);
        c1 = cyc;
        key_k_n = 1'b1;
        exp_held(c1 + D + 3, 2'b00);
        tick(D + 8);

        // simultaneous J and K
        c0 = cyc;
        key_j_n = 1'b0;
        key_k_n = 1'b0;
        exp_pulse(c0 + D + 3, 2'b11);
        exp_held(c0 + D + 3, 2'b11);
        tick(10);
        c1 = cyc;
        key_j_n = 1'b1;
        key_k_n = 1'b1;
        exp_held(c1 + D + 3, 2'b00);
        tick(D + 8);

        // reset at e3 of a J press, key still down afterwards
        key_j_n = 1'b0;
        tick(4);
        rst = 1'b0;
        #1;
        chk("reset_mid_press", int'({j, k, j_held, k_held}), 0);
        tick(2);
        c0 = cyc;
        rst = 1'b1;
        exp_pulse(c0 + D + 3, 2'b10);
        exp_held(c0 + D + 3, 2'b10);
        tick(D + 6);
        c1 = cyc;
        key_j_n = 1'b1;
        exp_held(c1 + D + 3, 2'b00);
        tick(D + 8);

        // reset while held must clear j_held without a clock edge
        c0 = cyc;
        key_j_n = 1'b0;
        exp_pulse(c0 + D + 3, 2'b10);
        exp_held(c0 + D + 3, 2'b10);
        tick(D + 6);
        exp_held(cyc, 2'b00);
        rst = 1'b0;
        #1;
        chk("reset_async_held", int'({j, k, j_held, k_held}), 0);
        key_j_n = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(D + 10);

        chk("pulse_events_outstanding", pulse_q.size(), 0);
        chk("held_events_outstanding", held_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
